jtag_tap_sync: RTL and testbench

//  JTAG TAP controller oversampled in the system clock domain; direct consumer of tck/tms/tdi from the JTAG bench driver, returns tdo.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_sync.sv | 33 +++
 rtl/jtag_tap_sync.sv | 78 +++++++
 tb/tb_jtag_tap_sync.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, IR opcodes and the 1149.1 TMS transition table.
package jtag_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR,
    SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR,
    UPDATE_DR, SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR,
    EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;
  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_t;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_BYPASS = 5'h1f;
  localparam logic [4:0] IR_USER_DEFAULT = 5'h11;
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/jtag_sync.sv
// jtag_sync: 2-FF synchronizers for tck/tms/tdi plus tck edge detection.
module jtag_sync (
  input  logic clock,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);
  logic [1:0] tck_m, tms_m, tdi_m;
  logic tck_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_m <= '0;
      tms_m <= '0;
      tdi_m <= '0;
      tck_d <= 1'b0;
    end else begin
      tck_m <= {tck_m[0], tck};
      tms_m <= {tms_m[0], tms};
      tdi_m <= {tdi_m[0], tdi};
      tck_d <= tck_m[1];
    end
  end
  // tms/tdi come from the same stage as tck so they are coherent with the detected edge
  assign tck_rise = tck_m[1] & ~tck_d;
  assign tck_fall = ~tck_m[1] & tck_d;
  assign tms_s = tms_m[1];
  assign tdi_s = tdi_m[1];
endmodule

// File: rtl/jtag_tap_sync.sv
// jtag_tap_sync: clock-domain oversampled JTAG TAP with IR, IDCODE, BYPASS and USER DRs.
module jtag_tap_sync
  import jtag_pkg::*;
#(
  parameter int IR_LEN = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h00000001,
  parameter int USER_DR_LEN = 41,
  parameter logic [IR_LEN-1:0] USER_IR = IR_LEN'(IR_USER_DEFAULT)
) (
  input  logic clock,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  output logic [3:0] tap_state,
  output logic [IR_LEN-1:0] ir_value,
  input  logic [USER_DR_LEN-1:0] user_dr_in,
  output logic [USER_DR_LEN-1:0] user_dr_out,
  output logic user_dr_update
);
  localparam int DR_W = USER_DR_LEN > 32 ? USER_DR_LEN : 32;
  logic tck_rise, tck_fall, tms_s, tdi_s;
  tap_state_t state, state_nx;
  dr_sel_t sel;
  logic [IR_LEN-1:0] ir_shift;
  logic [DR_W-1:0] dr_shift, dr_capture, dr_shifted, low_mask;
  logic [6:0] msb;
  jtag_sync u_sync (
    .clock(clock),
    .reset(reset),
    .tck(tck),
    .tms(tms),
    .tdi(tdi),
    .tck_rise(tck_rise),
    .tck_fall(tck_fall),
    .tms_s(tms_s),
    .tdi_s(tdi_s)
  );
  always_comb begin
    state_nx = tck_rise ? tap_next(state, tms_s) : state;
    sel = ir_value == IR_LEN'(IR_IDCODE) ? SEL_IDCODE : ir_value == USER_IR ? SEL_USER : SEL_BYPASS;
    msb = sel == SEL_IDCODE ? 7'd31 : sel == SEL_USER ? 7'(USER_DR_LEN - 1) : 7'd0;
    dr_capture = sel == SEL_IDCODE ? DR_W'(IDCODE_VAL) : sel == SEL_USER ? DR_W'(user_dr_in) : '0;
    low_mask = (DR_W'(1) << msb) - DR_W'(1);
    dr_shifted = ((dr_shift >> 1) & low_mask) | (DR_W'(tdi_s) << msb);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= TEST_LOGIC_RESET;
      ir_value <= IR_LEN'(IR_IDCODE);
      ir_shift <= '0;
      dr_shift <= '0;
      tdo <= 1'b0;
      tdo_en <= 1'b0;
      user_dr_out <= '0;
      user_dr_update <= 1'b0;
    end else begin
      state <= state_nx;
      user_dr_update <= tck_rise && state == UPDATE_DR && ir_value == USER_IR;
      if (tck_rise) begin
        if (state == CAPTURE_IR) ir_shift <= IR_LEN'(2'b01);
        if (state == SHIFT_IR) ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
        if (state == UPDATE_IR) ir_value <= ir_shift;
        if (state_nx == TEST_LOGIC_RESET) ir_value <= IR_LEN'(IR_IDCODE);
        if (state == CAPTURE_DR) dr_shift <= dr_capture;
        if (state == SHIFT_DR) dr_shift <= dr_shifted;
        if (state == UPDATE_DR && ir_value == USER_IR) user_dr_out <= dr_shift[USER_DR_LEN-1:0];
      end
      if (tck_fall) begin
        tdo <= state == SHIFT_IR ? ir_shift[0] : state == SHIFT_DR ? dr_shift[0] : 1'b0;
        tdo_en <= state == SHIFT_IR || state == SHIFT_DR;
      end
    end
  end
  assign tap_state = state;
endmodule

// File: tb/tb_jtag_tap_sync.sv
// tb_jtag_tap_sync: table-driven IR/DR scans with a scoreboard plus reset and TLR corner sequences.
module tb_jtag_tap_sync;
  import jtag_pkg::*;
  logic clock = 1'b0, reset = 1'b1, tck = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic tdo, tdo_en, user_dr_update;
  logic [3:0] tap_state;
  logic [4:0] ir_value;
  logic [40:0] user_dr_in = '0, user_dr_out;
  int n_checks = 0, n_fail = 0, upd_cnt = 0;
  logic [63:0] sb_q[$];
  typedef struct {
    logic [4:0] ir;
    int len;
    logic [63:0] din;
    logic [40:0] uin;
    logic [63:0] exp;
    logic [40:0] exp_uout;
    int exp_upd;
  } vec_t;
  vec_t tv[6];
  jtag_tap_sync dut (
    .clock(clock),
    .reset(reset),
    .tck(tck),
    .tms(tms),
    .tdi(tdi),
    .tdo(tdo),
    .tdo_en(tdo_en),
    .tap_state(tap_state),
    .ir_value(ir_value),
    .user_dr_in(user_dr_in),
    .user_dr_out(user_dr_out),
    .user_dr_update(user_dr_update)
  );
  always #20 clock = ~clock;
  always @(negedge clock) if (user_dr_update === 1'b1) upd_cnt++;
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tck_cycle(input logic m, input logic d, output logic o, output logic oe);
    tms = m;
    tdi = d;
    tck = 1'b0;
    #140;
    o = tdo;
    oe = tdo_en;
    tck = 1'b1;
    #110;
  endtask
  task automatic step(input logic m);
    logic o, oe;
    tck_cycle(m, 1'b0, o, oe);
  endtask
  task automatic shift(input bit is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o, oe;
    step(1'b1);
    if (is_ir) step(1'b1);
    step(1'b0);
    step(1'b0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o, oe);
      dout[i] = o;
      check(is_ir ? "tdo_en_shift_ir" : "tdo_en_shift_dr", 64'(oe), 64'h1);
    end
    step(1'b1);
    step(1'b0);
    repeat (6) @(posedge clock);
  endtask
  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(tap_state), 64'(TEST_LOGIC_RESET));
    check({tag, "_ir"}, 64'(ir_value), 64'h01);
    check({tag, "_tdo"}, 64'(tdo), 64'h0);
    check({tag, "_tdo_en"}, 64'(tdo_en), 64'h0);
    check({tag, "_uout"}, 64'(user_dr_out), 64'h0);
    check({tag, "_upd"}, 64'(user_dr_update), 64'h0);
  endtask
  initial begin
    logic [63:0] ir_o, dr_o;
    logic [40:0] uout_model;
    int upd_before;
    tv[0] = '{5'h01, 32, 64'h0, 41'h0, 64'h0000_0001, 41'h0, 0};
    tv[1] = '{5'h1f, 8, 64'hA5, 41'h0, 64'h4A, 41'h0, 0};
    tv[2] = '{5'h11, 41, 64'h0_DEAD_BEEF0, 41'h1_2345_6789A, 64'h1_2345_6789A, 41'h0_DEAD_BEEF0, 1};
    tv[3] = '{5'h07, 8, 64'h3C, 41'h0, 64'h78, 41'h0_DEAD_BEEF0, 0};
    tv[4] = '{5'h01, 40, 64'hC5, 41'h0, 64'hC5_0000_0001, 41'h0_DEAD_BEEF0, 0};
    tv[5] = '{5'h11, 45, 64'h5, 41'h0AB_CDEF_0123, 64'hAAB_CDEF_0123, 41'h0, 1};
    uout_model = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (4) @(posedge clock);
    step(1'b0);
    @(negedge clock);
    check("rti_state", 64'(tap_state), 64'(RUN_TEST_IDLE));
    check("rti_tdo_en", 64'(tdo_en), 64'h0);
    for (int k = 0; k < 8; k++) begin
      tms = k[0];
      tdi = k[1];
      repeat (3) @(posedge clock);
    end
    @(negedge clock);
    check("no_tck_no_move", 64'(tap_state), 64'(RUN_TEST_IDLE));
    foreach (tv[k]) begin
      user_dr_in = tv[k].uin;
      sb_q.push_back(64'h01);
      shift(1'b1, 5, 64'(tv[k].ir), ir_o);
      check($sformatf("vec%0d_ir_o", k), ir_o, sb_q.pop_front());
      check($sformatf("vec%0d_ir_value", k), 64'(ir_value), 64'(tv[k].ir));
      upd_before = upd_cnt;
      sb_q.push_back(tv[k].exp);
      shift(1'b0, tv[k].len, tv[k].din, dr_o);
      check($sformatf("vec%0d_dr_o", k), dr_o, sb_q.pop_front());
      check($sformatf("vec%0d_upd_clocks", k), 64'(upd_cnt - upd_before), 64'(tv[k].exp_upd));
      if (tv[k].exp_upd != 0) uout_model = tv[k].exp_uout;
      check($sformatf("vec%0d_uout", k), 64'(user_dr_out), 64'(uout_model));
      @(negedge clock);
      check($sformatf("vec%0d_idle_tdo_en", k), 64'(tdo_en), 64'h0);
    end
    sb_q.push_back(64'h01);
    shift(1'b1, 5, 64'h1f, ir_o);
    check("tlr_ir_o", ir_o, sb_q.pop_front());
    upd_before = upd_cnt;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("tlr_in_shift", 64'(tap_state), 64'(SHIFT_DR));
    repeat (5) step(1'b1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("tlr_state", 64'(tap_state), 64'(TEST_LOGIC_RESET));
    check("tlr_ir_value", 64'(ir_value), 64'h01);
    check("tlr_no_upd", 64'(upd_cnt - upd_before), 64'h0);
    check("tlr_uout_kept", 64'(user_dr_out), 64'(uout_model));
    step(1'b0);
    user_dr_in = 41'h1_5555_AAAA5;
    sb_q.push_back(64'h01);
    shift(1'b1, 5, 64'h11, ir_o);
    check("rst_ir_o", ir_o, sb_q.pop_front());
    upd_before = upd_cnt;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b0);
    tms = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("midshift_rst");
    reset = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("post_rst_no_upd", 64'(upd_cnt - upd_before), 64'h0);
    check("post_rst_state", 64'(tap_state), 64'(TEST_LOGIC_RESET));
    step(1'b0);
    sb_q.push_back(64'h0000_0001);
    shift(1'b0, 32, 64'h0, dr_o);
    check("post_rst_idcode", dr_o, sb_q.pop_front());
    check("post_rst_uout", 64'(user_dr_out), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
